// File: rtl/pipelined_if_id_stage_pkg.sv
// Shared constants for the IF/ID front end: reset values, instruction field
// positions and the hard-wired zero register.
package pipelined_if_id_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipelined_if_id_stage_hazard_detect.sv
// Load-use hazard check: the instruction in ID reads a register that a load
// in EXE has not yet produced.
module pipelined_hazard_detect
  import pipelined_if_id_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       exe_is_load,
  input  logic       exe_wreg,
  input  logic [4:0] exe_write_reg,
  output logic       hazard
);

  logic load_writes;
  logic rs_match;
  logic rt_match;

  // Writes to r0 are discarded, so they can never create a dependency.
  assign load_writes = exe_is_load & exe_wreg & (exe_write_reg != REG_ZERO);
  assign rs_match    = id_uses_rs & (exe_write_reg == id_rs);
  assign rt_match    = id_uses_rt & (exe_write_reg == id_rt);
  assign hazard      = id_valid & load_writes & (rs_match | rt_match);

endmodule

// File: rtl/pipelined_if_id_stage.sv
// Fetch front end: PC register, IF/ID pipeline register, load-use bubble
// generation, branch/jump redirect and stall/flush counters.
module pipelined_if_id_stage
  import pipelined_if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = pipelined_if_id_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = pipelined_if_id_stage_pkg::NOP_INST
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] IF_Inst,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_PC_plus4,
  output logic        ID_Valid,
  input  logic        ID_Uses_rs,
  input  logic        ID_Uses_rt,
  input  logic        ID_Redirect,
  input  logic [31:0] ID_Target,
  input  logic        EXE_Is_load,
  input  logic        EXE_Wreg,
  input  logic [4:0]  EXE_write_reg,
  output logic        Bubble,
  output logic [31:0] Stall_cnt,
  output logic [31:0] Flush_cnt
);

  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_plus4_reg;
  logic        valid_reg;
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;
  logic [31:0] pc_plus4;
  logic        hazard;
  logic        redirect_taken;

  assign pc_plus4 = pc_reg + PC_STEP;

  pipelined_hazard_detect u_hazard_detect (
    .id_valid      (valid_reg),
    .id_uses_rs    (ID_Uses_rs),
    .id_uses_rt    (ID_Uses_rt),
    .id_rs         (inst_reg[RS_MSB:RS_LSB]),
    .id_rt         (inst_reg[RT_MSB:RT_LSB]),
    .exe_is_load   (EXE_Is_load),
    .exe_wreg      (EXE_Wreg),
    .exe_write_reg (EXE_write_reg),
    .hazard        (hazard)
  );

  // A stalled branch's operands are not ready yet, so it must not redirect.
  assign redirect_taken = ID_Redirect & valid_reg & ~hazard;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pc_reg        <= RESET_PC;
      inst_reg      <= NOP_INST;
      pc_plus4_reg  <= 32'd0;
      valid_reg     <= 1'b0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else if (hazard) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end else if (redirect_taken) begin
      pc_reg        <= ID_Target;
      inst_reg      <= NOP_INST;
      pc_plus4_reg  <= 32'd0;
      valid_reg     <= 1'b0;
      flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end else begin
      pc_reg        <= pc_plus4;
      inst_reg      <= IF_Inst;
      pc_plus4_reg  <= pc_plus4;
      valid_reg     <= 1'b1;
    end
  end

  assign IF_PC       = pc_reg;
  assign ID_Inst     = inst_reg;
  assign ID_PC_plus4 = pc_plus4_reg;
  assign ID_Valid    = valid_reg;
  assign Bubble      = hazard;
  assign Stall_cnt   = stall_cnt_reg;
  assign Flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipelined_if_id_stage.sv
// Bench for the IF/ID front end: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_pipelined_if_id_stage;
  import pipelined_if_id_stage_pkg::*;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] IF_Inst;
  logic [31:0] IF_PC;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PC_plus4;
  logic        ID_Valid;
  logic        ID_Uses_rs;
  logic        ID_Uses_rt;
  logic        ID_Redirect;
  logic [31:0] ID_Target;
  logic        EXE_Is_load;
  logic        EXE_Wreg;
  logic [4:0]  EXE_write_reg;
  logic        Bubble;
  logic [31:0] Stall_cnt;
  logic [31:0] Flush_cnt;

  pipelined_if_id_stage dut (
    .Clk           (Clk),
    .Clrn          (Clrn),
    .IF_Inst       (IF_Inst),
    .IF_PC         (IF_PC),
    .ID_Inst       (ID_Inst),
    .ID_PC_plus4   (ID_PC_plus4),
    .ID_Valid      (ID_Valid),
    .ID_Uses_rs    (ID_Uses_rs),
    .ID_Uses_rt    (ID_Uses_rt),
    .ID_Redirect   (ID_Redirect),
    .ID_Target     (ID_Target),
    .EXE_Is_load   (EXE_Is_load),
    .EXE_Wreg      (EXE_Wreg),
    .EXE_write_reg (EXE_write_reg),
    .Bubble        (Bubble),
    .Stall_cnt     (Stall_cnt),
    .Flush_cnt     (Flush_cnt)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: the word is tagged with its address, rs = a[6:2], rt = a[11:7].
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {6'h23, a[6:2], a[11:7], a[15:0]};
  endfunction

  assign IF_Inst = imem(IF_PC);

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_step       = 0;

  logic [31:0] m_pc, m_inst, m_pc4, m_stall, m_flush;
  logic        m_valid;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_inst  = NOP_INST;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_stall = 32'd0;
    m_flush = 32'd0;
  endtask

  function automatic logic model_hazard();
    int unsigned rs = (m_inst >> 21) % 32;
    int unsigned rt = (m_inst >> 16) % 32;
    int unsigned wr = EXE_write_reg;
    if (!m_valid || !EXE_Is_load || !EXE_Wreg || wr == 0) return 1'b0;
    return (ID_Uses_rs && wr == rs) || (ID_Uses_rt && wr == rt);
  endfunction

  task automatic check_state();
    check_value("if_pc",       IF_PC,       m_pc);
    check_value("id_inst",     ID_Inst,     m_inst);
    check_value("id_pc_plus4", ID_PC_plus4, m_pc4);
    check_value("id_valid",    ID_Valid,    m_valid);
    check_value("stall_cnt",   Stall_cnt,   m_stall);
    check_value("flush_cnt",   Flush_cnt,   m_flush);
  endtask

  // One clock: apply inputs, check the bubble, advance the model, check state.
  task automatic step(input logic u_rs, input logic u_rt, input logic rd,
                      input logic [31:0] tgt, input logic ld, input logic wr,
                      input logic [4:0] wreg);
    logic hz;
    ID_Uses_rs    = u_rs;
    ID_Uses_rt    = u_rt;
    ID_Redirect   = rd;
    ID_Target     = tgt;
    EXE_Is_load   = ld;
    EXE_Wreg      = wr;
    EXE_write_reg = wreg;
    #1;
    hz = model_hazard();
    check_value("bubble", Bubble, hz);
    if (hz) begin
      m_stall = m_stall + 32'd1;
    end else if (rd && m_valid) begin
      m_pc    = tgt;
      m_inst  = NOP_INST;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
      m_flush = m_flush + 32'd1;
    end else begin
      m_inst  = imem(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    @(posedge Clk);
    #1;
    check_state();
    n_step++;
    $display("step %0d: bubble=%0b redirect=%0b pc=%h id_inst=%h valid=%0b stalls=%0d flushes=%0d",
             n_step, hz, rd, IF_PC, ID_Inst, ID_Valid, Stall_cnt, Flush_cnt);
  endtask

  task automatic plain();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    logic [4:0]  r;
    logic [31:0] t;
    Clrn = 1'b0;
    ID_Uses_rs = 1'b1; ID_Uses_rt = 1'b1; ID_Redirect = 1'b1; ID_Target = 32'h40;
    EXE_Is_load = 1'b1; EXE_Wreg = 1'b1; EXE_write_reg = 5'd3;
    #2;
    check_value("rst_pc",     IF_PC,       RESET_PC);
    check_value("rst_inst",   ID_Inst,     NOP_INST);
    check_value("rst_pc4",    ID_PC_plus4, 32'd0);
    check_value("rst_valid",  ID_Valid,    1'b0);
    check_value("rst_bubble", Bubble,      1'b0);
    check_value("rst_stall",  Stall_cnt,   32'd0);
    check_value("rst_flush",  Flush_cnt,   32'd0);
    @(posedge Clk);
    #3;
    Clrn = 1'b1;
    model_reset();

    // Free run: after six fetches ID holds the word from 0x14 (rs = 5).
    repeat (6) plain();

    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd5);
    check_value("stall_one", Stall_cnt, 32'd1);
    check_value("pc_hold",   IF_PC,     32'h18);
    plain();
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 5'd0);
    r = m_inst[25:21];
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, r);

    // Redirect to 0x100, then the target word arrives one slot later.
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 5'd0);
    check_value("redir_pc",    IF_PC,     32'h100);
    check_value("redir_valid", ID_Valid,  1'b0);
    check_value("redir_flush", Flush_cnt, 32'd1);
    plain();
    check_value("target_word", ID_Inst, imem(32'h100));
    plain();

    // Hazard and redirect together: the stall wins, redirect is taken next cycle.
    r = m_inst[20:16];
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, r);
    check_value("both_flush", Flush_cnt, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 5'd0);
    check_value("late_redir_pc", IF_PC,     32'h200);
    check_value("late_flush",    Flush_cnt, 32'd2);

    // PC wrap from the top of the address space.
    plain();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 5'd0);
    plain();
    check_value("wrap_pc",  IF_PC,       32'd0);
    check_value("wrap_pc4", ID_PC_plus4, 32'd0);

    // Counter wrap from preloaded values.
    force dut.flush_cnt_reg = 32'hFFFF_FFFE;
    release dut.flush_cnt_reg;
    m_flush = 32'hFFFF_FFFE;
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 5'd0);
    plain();
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 5'd0);
    check_value("flush_wrap", Flush_cnt, 32'd0);
    plain();
    force dut.stall_cnt_reg = 32'hFFFF_FFFF;
    release dut.stall_cnt_reg;
    m_stall = 32'hFFFF_FFFF;
    r = m_inst[25:21];
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, r);
    check_value("stall_wrap", Stall_cnt, 32'd0);

    // Randomized traffic, biased toward real register matches.
    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       r = m_inst[25:21];
        1:       r = m_inst[20:16];
        2:       r = 5'($urandom_range(0, 31));
        default: r = 5'd0;
      endcase
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, t,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, r);
    end

    // Asynchronous reset in the middle of a stall.
    plain();
    step(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 5'd0);
    plain();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd5);
    check_value("pre_rst_bubble", Bubble, 1'b1);
    #2;
    Clrn = 1'b0;
    #1;
    check_value("arst_pc",     IF_PC,     RESET_PC);
    check_value("arst_inst",   ID_Inst,   NOP_INST);
    check_value("arst_valid",  ID_Valid,  1'b0);
    check_value("arst_bubble", Bubble,    1'b0);
    check_value("arst_stall",  Stall_cnt, 32'd0);
    check_value("arst_flush",  Flush_cnt, 32'd0);
    @(negedge Clk);
    Clrn = 1'b1;
    model_reset();
    plain();
    check_value("first_fetch", ID_PC_plus4, RESET_PC + 32'd4);
    plain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
